mem_arbiter: RTL and testbench

- Sits between the core's fetch unit (IFU) and load/store unit (LSU) and the single shared ram_rw port that the top level drives into RAMHelper.
- Arbitrates between the two requesters and keeps exactly one transaction outstanding.
- On the RAM side it generates cen/wen/addr/wdata/wmask/size.
- On the response side it extracts, aligns and sign/zero-extends read data before returning it to the winner.

---
 rtl/mem_arbiter_pkg.sv | 30 +++
 rtl/mem_lane_align.sv | 42 ++++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the IFU/LSU memory arbiter: FSM states, access sizes, owners.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    MA_IDLE  = 2'd0,
    MA_ISSUE = 2'd1,
    MA_WAIT  = 2'd2,
    MA_RESP  = 2'd3
  } ma_state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  function automatic logic [7:0] base_mask(input logic [1:0] sz);
    case (sz)
      SZ_B:    base_mask = 8'h01;
      SZ_H:    base_mask = 8'h03;
      SZ_W:    base_mask = 8'h0F;
      default: base_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store data/mask placement, load extraction with
// sign/zero extension, and natural-alignment check.
module mem_lane_align
  import mem_arbiter_pkg::*;
(
  input  logic [2:0]  off,
  input  logic [2:0]  size,
  input  logic [63:0] data,
  output logic [63:0] wdata,
  output logic [7:0]  wmask,
  output logic [63:0] rdata,
  output logic        misalign
);

  logic [63:0] shifted;

  assign wdata   = data << {off, 3'b000};
  assign wmask   = base_mask(size[1:0]) << off;
  assign shifted = data >> {off, 3'b000};

  // size[2] selects zero extension
  always_comb begin
    rdata    = '0;
    misalign = 1'b0;
    case (size[1:0])
      SZ_B: rdata = size[2] ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}}, shifted[7:0]};
      SZ_H: begin
        rdata    = size[2] ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
        misalign = off[0];
      end
      SZ_W: begin
        rdata    = size[2] ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
        misalign = |off[1:0];
      end
      default: begin
        rdata    = shifted;
        misalign = |off;
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch, load/store) arbiter onto a single RAM port with one
// transaction outstanding; responses are lane-aligned and extended.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter bit ARB_RR = 1'b0,
  parameter int ADDR_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ifu_req_valid_i,
  output logic              ifu_req_ready_o,
  input  logic [ADDR_W-1:0] ifu_addr_i,
  output logic              ifu_resp_valid_o,
  output logic [31:0]       ifu_instr_o,
  input  logic              lsu_req_valid_i,
  output logic              lsu_req_ready_o,
  input  logic              lsu_wen_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [63:0]       lsu_wdata_i,
  input  logic [2:0]        lsu_size_i,
  output logic              lsu_resp_valid_o,
  output logic [63:0]       lsu_rdata_o,
  output logic              lsu_misalign_o,
  output logic              ram_rw_cen_o,
  output logic              ram_rw_wen_o,
  output logic [ADDR_W-1:0] ram_rw_addr_o,
  output logic [63:0]       ram_rw_wdata_o,
  output logic [7:0]        ram_rw_wmask_o,
  output logic [2:0]        ram_rw_size_o,
  input  logic              ram_rw_ready_i,
  input  logic [63:0]       ram_rw_data_i
);

  ma_state_t         state, state_nxt;
  owner_t            owner_q, last_q;
  logic [2:0]        off_q, size_q;
  logic              wen_q;
  logic              idle, prefer_ls, grant_ls, grant_if, accept, ls_store;
  logic [ADDR_W-1:0] req_addr;

  logic [2:0]  la_off, la_size;
  logic [63:0] la_data, la_wdata, la_rdata;
  logic [7:0]  la_wmask;
  logic        la_mis;

  assign idle      = (state == MA_IDLE) && !reset;
  assign prefer_ls = !ARB_RR || (last_q == OWN_IF);
  assign grant_ls  = lsu_req_valid_i && (!ifu_req_valid_i || prefer_ls);
  assign grant_if  = ifu_req_valid_i && !grant_ls;
  assign accept    = idle && (grant_ls || grant_if);
  assign ls_store  = grant_ls && lsu_wen_i;
  assign req_addr  = grant_ls ? lsu_addr_i : ifu_addr_i;

  assign lsu_req_ready_o = idle && grant_ls;
  assign ifu_req_ready_o = idle && grant_if;

  // One aligner: request-side placement in IDLE, response extraction afterwards
  assign la_off  = (state == MA_IDLE) ? req_addr[2:0] : off_q;
  assign la_size = (state == MA_IDLE) ? lsu_size_i    : size_q;
  assign la_data = (state == MA_IDLE) ? lsu_wdata_i   : ram_rw_data_i;

  mem_lane_align u_align (
    .off      (la_off),
    .size     (la_size),
    .data     (la_data),
    .wdata    (la_wdata),
    .wmask    (la_wmask),
    .rdata    (la_rdata),
    .misalign (la_mis)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= MA_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MA_IDLE:  if (accept) state_nxt = (grant_ls && la_mis) ? MA_RESP : MA_ISSUE;
      MA_ISSUE: state_nxt = MA_WAIT;
      MA_WAIT:  if (ram_rw_ready_i) state_nxt = MA_RESP;
      default:  state_nxt = MA_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_q          <= OWN_IF;
      last_q           <= OWN_IF;
      off_q            <= '0;
      size_q           <= '0;
      wen_q            <= 1'b0;
      ram_rw_cen_o     <= 1'b0;
      ram_rw_wen_o     <= 1'b0;
      ram_rw_addr_o    <= '0;
      ram_rw_wdata_o   <= '0;
      ram_rw_wmask_o   <= '0;
      ram_rw_size_o    <= '0;
      ifu_resp_valid_o <= 1'b0;
      ifu_instr_o      <= '0;
      lsu_resp_valid_o <= 1'b0;
      lsu_rdata_o      <= '0;
      lsu_misalign_o   <= 1'b0;
    end else begin
      ram_rw_cen_o     <= 1'b0;
      ram_rw_wen_o     <= 1'b0;
      ifu_resp_valid_o <= 1'b0;
      lsu_resp_valid_o <= 1'b0;
      lsu_misalign_o   <= 1'b0;
      case (state)
        MA_IDLE: if (accept) begin
          owner_q <= grant_ls ? OWN_LS : OWN_IF;
          last_q  <= grant_ls ? OWN_LS : OWN_IF;
          off_q   <= req_addr[2:0];
          size_q  <= lsu_size_i;
          wen_q   <= ls_store;
          if (grant_ls && la_mis) begin
            // dropped without touching RAM
            lsu_resp_valid_o <= 1'b1;
            lsu_misalign_o   <= 1'b1;
            lsu_rdata_o      <= '0;
          end else begin
            ram_rw_cen_o   <= 1'b1;
            ram_rw_wen_o   <= ls_store;
            ram_rw_addr_o  <= {req_addr[ADDR_W-1:3], 3'b000};
            ram_rw_wdata_o <= ls_store ? la_wdata : 64'd0;
            ram_rw_wmask_o <= ls_store ? la_wmask : 8'd0;
            ram_rw_size_o  <= grant_ls ? {1'b0, lsu_size_i[1:0]} : {1'b0, SZ_W};
          end
        end
        MA_WAIT: if (ram_rw_ready_i) begin
          if (owner_q == OWN_LS) begin
            lsu_resp_valid_o <= 1'b1;
            lsu_rdata_o      <= wen_q ? 64'd0 : la_rdata;
          end else begin
            ifu_resp_valid_o <= 1'b1;
            ifu_instr_o      <= off_q[2] ? ram_rw_data_i[63:32] : ram_rw_data_i[31:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fixed-priority instance (dut0) and round-robin
// instance (dut1) share stimulus; each has its own one-cycle-latency RAM responder.
module tb_mem_arbiter;

  logic        clock, reset;
  logic        ifu_valid, lsu_valid, lsu_wen;
  logic [63:0] ifu_addr, lsu_addr, lsu_wdata, ram_data;
  logic [2:0]  lsu_size;
  logic        ram_stall;

  logic        ifu_ready0, ifu_resp0, lsu_ready0, lsu_resp0, mis0, cen0, wen0, rdy0;
  logic [31:0] instr0;
  logic [63:0] rdata0, addr0, wdata0;
  logic [7:0]  wmask0;
  logic [2:0]  size0;

  logic        ifu_ready1, ifu_resp1, lsu_ready1, lsu_resp1, mis1, cen1, wen1, rdy1;
  logic [31:0] instr1;
  logic [63:0] rdata1, addr1, wdata1;
  logic [7:0]  wmask1;
  logic [2:0]  size1;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ARB_RR(1'b0), .ADDR_W(64)) dut0 (
    .clock(clock), .reset(reset),
    .ifu_req_valid_i(ifu_valid), .ifu_req_ready_o(ifu_ready0), .ifu_addr_i(ifu_addr),
    .ifu_resp_valid_o(ifu_resp0), .ifu_instr_o(instr0),
    .lsu_req_valid_i(lsu_valid), .lsu_req_ready_o(lsu_ready0), .lsu_wen_i(lsu_wen),
    .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata), .lsu_size_i(lsu_size),
    .lsu_resp_valid_o(lsu_resp0), .lsu_rdata_o(rdata0), .lsu_misalign_o(mis0),
    .ram_rw_cen_o(cen0), .ram_rw_wen_o(wen0), .ram_rw_addr_o(addr0),
    .ram_rw_wdata_o(wdata0), .ram_rw_wmask_o(wmask0), .ram_rw_size_o(size0),
    .ram_rw_ready_i(rdy0), .ram_rw_data_i(ram_data)
  );

  mem_arbiter #(.ARB_RR(1'b1), .ADDR_W(64)) dut1 (
    .clock(clock), .reset(reset),
    .ifu_req_valid_i(ifu_valid), .ifu_req_ready_o(ifu_ready1), .ifu_addr_i(ifu_addr),
    .ifu_resp_valid_o(ifu_resp1), .ifu_instr_o(instr1),
    .lsu_req_valid_i(lsu_valid), .lsu_req_ready_o(lsu_ready1), .lsu_wen_i(lsu_wen),
    .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata), .lsu_size_i(lsu_size),
    .lsu_resp_valid_o(lsu_resp1), .lsu_rdata_o(rdata1), .lsu_misalign_o(mis1),
    .ram_rw_cen_o(cen1), .ram_rw_wen_o(wen1), .ram_rw_addr_o(addr1),
    .ram_rw_wdata_o(wdata1), .ram_rw_wmask_o(wmask1), .ram_rw_size_o(size1),
    .ram_rw_ready_i(rdy1), .ram_rw_data_i(ram_data)
  );

  always #5 clock = ~clock;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      rdy0 <= 1'b0;
      rdy1 <= 1'b0;
    end else begin
      rdy0 <= cen0 && !ram_stall;
      rdy1 <= cen1 && !ram_stall;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic run_fetch(input string tag, input logic [63:0] a, input logic [31:0] exp_instr);
    ifu_addr  = a;
    ifu_valid = 1'b1;
    @(negedge clock);
    chk({tag, "_ifu_ready"}, 64'(ifu_ready0), 64'd1);
    chk({tag, "_lsu_ready"}, 64'(lsu_ready0), 64'd0);
    tick();
    ifu_valid = 1'b0;
    @(negedge clock);
    chk({tag, "_cen"},  64'(cen0), 64'd1);
    chk({tag, "_addr"}, addr0, {a[63:3], 3'b000});
    chk({tag, "_size"}, 64'(size0), 64'd2);
    chk({tag, "_wen"},  64'(wen0), 64'd0);
    tick();
    @(negedge clock);
    chk({tag, "_cen_c2"},  64'(cen0), 64'd0);
    chk({tag, "_resp_c2"}, 64'(ifu_resp0), 64'd0);
    tick();
    @(negedge clock);
    chk({tag, "_resp"},  64'(ifu_resp0), 64'd1);
    chk({tag, "_instr"}, 64'(instr0), 64'(exp_instr));
    tick();
    @(negedge clock);
    chk({tag, "_resp_c4"}, 64'(ifu_resp0), 64'd0);
  endtask

  task automatic run_lsu(input string tag, input logic w, input logic [63:0] a,
                         input logic [63:0] wd, input logic [2:0] sz,
                         input logic [63:0] exp_wdata, input logic [7:0] exp_wmask,
                         input logic [2:0] exp_size, input logic [63:0] exp_rdata);
    lsu_wen   = w;
    lsu_addr  = a;
    lsu_wdata = wd;
    lsu_size  = sz;
    lsu_valid = 1'b1;
    @(negedge clock);
    chk({tag, "_ready"}, 64'(lsu_ready0), 64'd1);
    tick();
    lsu_valid = 1'b0;
    @(negedge clock);
    chk({tag, "_cen"},   64'(cen0), 64'd1);
    chk({tag, "_wen"},   64'(wen0), 64'(w));
    chk({tag, "_addr"},  addr0, {a[63:3], 3'b000});
    chk({tag, "_wdata"}, wdata0, exp_wdata);
    chk({tag, "_wmask"}, 64'(wmask0), 64'(exp_wmask));
    chk({tag, "_size"},  64'(size0), 64'(exp_size));
    tick();
    @(negedge clock);
    chk({tag, "_resp_c2"}, 64'(lsu_resp0), 64'd0);
    tick();
    @(negedge clock);
    chk({tag, "_resp"},  64'(lsu_resp0), 64'd1);
    chk({tag, "_mis"},   64'(mis0), 64'd0);
    chk({tag, "_rdata"}, rdata0, exp_rdata);
    tick();
  endtask

  initial begin
    clock = 1'b0; reset = 1'b1; ram_stall = 1'b0;
    ifu_valid = 1'b1; lsu_valid = 1'b1; lsu_wen = 1'b0;
    ifu_addr = '0; lsu_addr = '0; lsu_wdata = '0; lsu_size = '0; ram_data = '0;

    // reset state: ready suppressed even with both requesters valid
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_ifu_ready", 64'(ifu_ready0), 64'd0);
    chk("rst_lsu_ready", 64'(lsu_ready0), 64'd0);
    chk("rst_cen",       64'(cen0), 64'd0);
    chk("rst_addr",      addr0, 64'd0);
    chk("rst_resp",      64'({ifu_resp0, lsu_resp0, mis0}), 64'd0);
    ifu_valid = 1'b0; lsu_valid = 1'b0;
    tick();
    reset = 1'b0;

    ram_data = 64'h1111_2222_3333_4444;
    run_fetch("fetch_hi", 64'h8000_0004, 32'h1111_2222);
    tick();

    ram_data = 64'h0000_8000_0000_0000;
    run_lsu("lb",  1'b0, 64'h1005, 64'd0, 3'b000, 64'd0, 8'h00, 3'd0, 64'hFFFF_FFFF_FFFF_FF80);
    run_lsu("lbu", 1'b0, 64'h1005, 64'd0, 3'b100, 64'd0, 8'h00, 3'd0, 64'h0000_0000_0000_0080);
    run_lsu("sh",  1'b1, 64'h2002, 64'hBEEF, 3'b001, 64'h0000_0000_BEEF_0000, 8'h0C, 3'd1, 64'd0);
    ram_data = 64'h8765_4321_0000_0000;
    run_lsu("lw",  1'b0, 64'h3004, 64'd0, 3'b010, 64'd0, 8'h00, 3'd2, 64'hFFFF_FFFF_8765_4321);
    ram_data = 64'hF00D_0000_0000_0000;
    run_lsu("lhu", 1'b0, 64'h3006, 64'd0, 3'b101, 64'd0, 8'h00, 3'd1, 64'h0000_0000_0000_F00D);
    run_lsu("sd",  1'b1, 64'h4000, 64'h0123_4567_89AB_CDEF, 3'b011,
            64'h0123_4567_89AB_CDEF, 8'hFF, 3'd3, 64'd0);

    // misaligned LW: straight to response, no RAM access
    lsu_wen = 1'b0; lsu_addr = 64'h5002; lsu_size = 3'b010; lsu_valid = 1'b1;
    @(negedge clock);
    chk("mis_ready", 64'(lsu_ready0), 64'd1);
    chk("mis_cen0",  64'(cen0), 64'd0);
    tick();
    lsu_valid = 1'b0;
    @(negedge clock);
    chk("mis_resp",  64'(lsu_resp0), 64'd1);
    chk("mis_flag",  64'(mis0), 64'd1);
    chk("mis_rdata", rdata0, 64'd0);
    chk("mis_cen1",  64'(cen0), 64'd0);
    tick();
    @(negedge clock);
    chk("mis_resp_end", 64'({lsu_resp0, mis0, cen0}), 64'd0);
    tick();

    // tie with both held valid: fixed priority keeps LSU, round-robin alternates
    do_reset();
    ram_data = 64'h1111_2222_3333_4444;
    ifu_addr = 64'h8000_0000; lsu_addr = 64'h1005; lsu_size = 3'b000; lsu_wen = 1'b0;
    ifu_valid = 1'b1; lsu_valid = 1'b1;
    @(negedge clock);
    chk("tie0_fp", 64'({lsu_ready0, ifu_ready0}), 64'b10);
    chk("tie0_rr", 64'({lsu_ready1, ifu_ready1}), 64'b10);
    tick();
    @(negedge clock);
    chk("tie1_fp_busy", 64'({lsu_ready0, ifu_ready0}), 64'b00);
    repeat (3) tick();
    @(negedge clock);
    chk("tie4_fp", 64'({lsu_ready0, ifu_ready0}), 64'b10);
    chk("tie4_rr", 64'({lsu_ready1, ifu_ready1}), 64'b01);
    repeat (3) tick();
    @(negedge clock);
    chk("tie7_rr_resp",  64'(ifu_resp1), 64'd1);
    chk("tie7_rr_instr", 64'(instr1), 64'h3333_4444);
    chk("tie7_fp_resp",  64'(lsu_resp0), 64'd1);
    tick();
    @(negedge clock);
    chk("tie8_rr", 64'({lsu_ready1, ifu_ready1}), 64'b10);
    tick();
    ifu_valid = 1'b0; lsu_valid = 1'b0;
    repeat (3) tick();

    // fixed priority: loser IFU retries and is granted at cycle 4
    do_reset();
    ifu_valid = 1'b1; lsu_valid = 1'b1;
    @(negedge clock);
    chk("fp_c0", 64'({lsu_ready0, ifu_ready0}), 64'b10);
    tick();
    lsu_valid = 1'b0;
    @(negedge clock);
    chk("fp_c1_ifu", 64'(ifu_ready0), 64'd0);
    repeat (3) tick();
    @(negedge clock);
    chk("fp_c4_ifu", 64'(ifu_ready0), 64'd1);
    tick();
    ifu_valid = 1'b0;
    repeat (3) tick();

    // reset while stalled in WAIT: outputs clear at once, no late response
    ram_stall = 1'b1;
    ifu_addr = 64'h8000_0000; ifu_valid = 1'b1;
    tick();
    ifu_valid = 1'b0;
    @(negedge clock);
    chk("rw_cen", 64'(cen0), 64'd1);
    repeat (2) tick();
    @(negedge clock);
    chk("rw_stalled", 64'(ifu_resp0), 64'd0);
    #2 reset = 1'b1;
    #1;
    chk("rw_async_addr", addr0, 64'd0);
    chk("rw_async_size", 64'(size0), 64'd0);
    chk("rw_async_out",  64'({cen0, ifu_resp0, lsu_resp0, mis0}), 64'd0);
    tick();
    ram_stall = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("rw_no_resp", 64'({ifu_resp0, lsu_resp0, cen0}), 64'd0);
    end
    tick();
    run_fetch("post_rst", 64'h8000_0000, 32'h3333_4444);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
